aes128_key_schedule: RTL and testbench
======================================

Name: aes128_key_schedule

Overview:
Iterative AES-128 key-expansion stage. It sits directly upstream of the encryption core. From a 128-bit cipher key it produces round keys 0..10, one per cycle, over a valid/ready stream. It also keeps all 11 round keys in an internal store, so a later decryption core can read them by index in any order.

Parameters:
NR, 10, number of rounds; fixed for AES-128, with round keys indexed 0..NR
KW, 128, key and round-key width in bits

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  1-cycle request to expand key_in; ignored unless idle
key_in  input  128  cipher key; sampled only on an accepted start
rk_valid  output  1  rk_data/rk_index hold a valid round key
rk_ready  input  1  consumer accepts the round key this cycle
rk_data  output  128  current round key, with byte 0 in bits [127:120]
rk_index  output  4  round number (0..10) of rk_data
rd_index  input  4  random-access read index into the key store
rd_key  output  128  stored round key at rd_index (combinational)
busy  output  1  expansion in progress
done  output  1  1-cycle pulse after round key 10 is accepted
keys_valid  output  1  key store holds a complete schedule

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - rk_valid, busy, done and keys_valid to 0;
  - rk_data and rk_index to 0;
  - all 11 key-store entries to 0.
- States: IDLE, EMIT, FINISH.
- IDLE:
  - busy=0.
  - start=1 at a clock edge: w <= key_in, round <= 0, keys_valid <= 0, go to EMIT.
- EMIT:
  - busy=1, rk_valid=1, rk_data=w, rk_index=round.
  - On handshake (rk_valid & rk_ready), store[round] <= w.
  - If round==10, go to FINISH.
  - Otherwise w <= next(w, round+1) and round <= round+1; stay in EMIT.
  - Without a handshake, w and round hold, so rk_data and rk_index stay stable under backpressure.
- FINISH:
  - done=1 for exactly one cycle, keys_valid <= 1, busy=1, rk_valid=0.
  - Next state IDLE.
- next(w, r), with w split into words w0..w3 (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0};
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord rotates the word left by one byte; SubWord applies the AES S-box to each of the 4 bytes.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Latency:
  - rk_valid rises in the cycle after start is accepted.
  - With rk_ready held high, keys 0..10 transfer in 11 consecutive cycles and done pulses in the 12th.
- A start while busy (EMIT or FINISH) is ignored; it is neither queued nor allowed to corrupt w.
- rd_key:
  - returns store[rd_index] for rd_index 0..10 and 128'h0 for 11..15;
  - entries are readable as soon as they are written, but only guaranteed complete when keys_valid=1.
- A new start clears keys_valid. Store entries are overwritten progressively as handshakes occur.
- Reset asserted mid-expansion aborts immediately to the reset values, with no done pulse. Once reset is released, a start is accepted in IDLE.
- rk_ready while rk_valid=0 has no effect.

Decomposition:
- Shared package (aes_pkg): NR, KW, the Rcon table and a byte/word helper typedef. The encryption and decryption cores reuse all of these.
- Sub-module aes_sbox: combinational 8-bit S-box lookup, 4 instances here for SubWord. It is the same module the encryption core uses for SubBytes.

Test Plan:
1. Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1.
   -> rk_index 0..10 on consecutive cycles; key 1 = a0fafe1788542cb123a339392a6c7605; key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once in cycle 12; keys_valid=1.
2. Same key, with rk_ready toggling pseudo-randomly (low about 50% of cycles).
   -> identical 11-key sequence; rk_data and rk_index stable during every stall; done only after key 10 is accepted.
3. After scenario 1, sweep rd_index 0..15.
   -> rd_key[0]=2b7e…4f3c, rd_key[10]=d014…0ca6, indices 11..15 return 0.
4. Pulse start with key 000102030405060708090a0b0c0d0e0f while in EMIT at round 4.
   -> ignored; the remaining keys still match the original key's schedule.
5. Drive reset=0 during EMIT at round 6, then release.
   -> outputs return to 0 immediately; no done pulse; keys_valid=0. A fresh start with key 000102…0f yields key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
6. Issue back-to-back expansions, with start asserted the cycle after done.
   -> second start accepted; keys_valid drops and then rises again after the second done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: round count, key width, Rcon and byte/word types.
// Used by the key schedule and by the encryption/decryption cores.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  rnd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_FINISH
  } ks_state_e;

  localparam rnd_t LAST_RND = rnd_t'(NR);

  // Round constant for rounds 1..NR; round 0 never uses one.
  function automatic byte_t rcon(input rnd_t r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, one byte in, one byte out.
// Shared with the encryption core's SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: streams round keys 0..10 one per cycle after start, holding
// rk_data stable while rk_ready is low, and keeps every accepted key in a store for random-access reads.
module aes128_key_schedule
  import aes_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_data,
  output logic [3:0]    rk_index,
  input  logic [3:0]    rd_index,
  output logic [KW-1:0] rd_key,
  output logic          busy,
  output logic          done,
  output logic          keys_valid
);

  ks_state_e     state_q;
  logic [KW-1:0] w_q;
  logic [KW-1:0] w_d;
  rnd_t          round_q;
  rnd_t          round_d;
  logic          rk_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          keys_valid_q;
  logic [KW-1:0] store_q [0:NR];

  word_t rot_w3;
  word_t sub_w3;
  word_t t_w;
  word_t w0_n, w1_n, w2_n, w3_n;

  assign round_d = round_q + 4'd1;
  assign rot_w3  = rot_word(w_q[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot_w3[8*b +: 8]),
      .s_o (sub_w3[8*b +: 8])
    );
  end

  // Next round key is prepared every cycle; it only lands in w_q on a handshake.
  assign t_w  = sub_w3 ^ {rcon(round_d), 24'h0};
  assign w0_n = w_q[127:96] ^ t_w;
  assign w1_n = w_q[95:64]  ^ w0_n;
  assign w2_n = w_q[63:32]  ^ w1_n;
  assign w3_n = w_q[31:0]   ^ w2_n;
  assign w_d  = {w0_n, w1_n, w2_n, w3_n};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      round_q      <= '0;
      rk_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_q          <= key_in;
            round_q      <= '0;
            keys_valid_q <= 1'b0;
            rk_valid_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            store_q[round_q] <= w_q;
            if (round_q == LAST_RND) begin
              rk_valid_q   <= 1'b0;
              done_q       <= 1'b1;
              keys_valid_q <= 1'b1;
              state_q      <= ST_FINISH;
            end else begin
              w_q     <= w_d;
              round_q <= round_d;
            end
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rk_valid   = rk_valid_q;
  assign rk_data    = w_q;
  assign rk_index   = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = (rd_index <= LAST_RND) ? store_q[rd_index] : '0;

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench: FIPS-197 style reference key expansion with an S-box derived from GF(2^8) inversion.
module tb_aes128_key_schedule;

  localparam int NR = 10;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic [3:0]   rd_index = '0;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
  logic         keys_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb_ref [256];
  logic [127:0] ek [0:NR];
  logic [127:0] obs_keys [0:NR];

  always #5 clock = ~clock;

  aes128_key_schedule dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_index   (rk_index),
    .rd_index   (rd_index),
    .rd_key     (rd_key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] av  = 8'(a);
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
      sb_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one expansion; optionally pulses a stray start at inj_round or asserts reset at rst_round.
  task automatic expand(input logic [127:0] key, input int rdy_pct, input int inj_round, input int rst_round);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit injected = 1'b0;
    expand_ref(key);
    start = 1'b1; key_in = key; rk_ready = 1'b0;
    step();
    start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    chk("valid_after_start", rk_valid, 1);
    chk("kv_cleared_on_start", keys_valid, 0);
    while (idx <= NR && cyc < 400) begin
      chk("rk_valid", rk_valid, 1);
      chk("rk_index", rk_index, idx);
      chk("rk_data", rk_data, ek[idx]);
      chk("busy_emit", busy, 1);
      chk("no_early_done", done, 0);
      if (idx == rst_round) begin
        reset = 1'b0; rd_index = 4'd0;
        #1;
        chk("rst_rk_valid", rk_valid, 0);
        chk("rst_rk_data", rk_data, 0);
        chk("rst_rk_index", rk_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_keys_valid", keys_valid, 0);
        chk("rst_store", rd_key, 0);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          chk("post_rst_no_done", done, 0);
          chk("post_rst_idle", rk_valid, 0);
          chk("post_rst_kv", keys_valid, 0);
        end
        return;
      end
      if (idx == inj_round && !injected) begin
        start = 1'b1; key_in = K2; injected = 1'b1;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      rk_ready = rdy;
      if (rdy) obs_keys[idx] = rk_data;
      step();
      start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    chk("expand_completed", idx, NR + 1);
    if (rdy_pct == 100) chk("stream_cycles", cyc, 11);
    chk("done_pulse", done, 1);
    chk("finish_rk_valid", rk_valid, 0);
    chk("finish_busy", busy, 1);
    rk_ready = 1'($urandom_range(1));
    step();
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
    chk("keys_valid_set", keys_valid, 1);
    chk("idle_rk_valid", rk_valid, 0);
  endtask

  task automatic sweep_store();
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      chk("rd_key", rd_key, (i <= NR) ? ek[i] : 128'h0);
      step();
    end
  endtask

  initial begin
    build_sbox();
    repeat (2) step();
    chk("reset_rk_valid", rk_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_keys_valid", keys_valid, 0);
    chk("reset_rk_data", rk_data, 0);
    chk("reset_rk_index", rk_index, 0);
    chk("reset_store", rd_key, 0);
    reset = 1'b1;
    step();

    expand(K1, 100, -1, -1);
    chk("key0_const", obs_keys[0], K1);
    chk("key1_const", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("key10_const", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    sweep_store();
    rd_index = 4'd0; #1;
    chk("rd0_const", rd_key, K1);
    rd_index = 4'd10; #1;
    chk("rd10_const", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step();

    expand(K1, 50, -1, -1);
    expand(K1, 70, 4, -1);
    expand(K1, 100, -1, 6);

    expand(K2, 100, -1, -1);
    chk("k2_key10_const", obs_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    expand({$urandom, $urandom, $urandom, $urandom}, 60, -1, -1);
    expand({$urandom, $urandom, $urandom, $urandom}, 60, -1, -1);
    sweep_store();

    for (int n = 0; n < 3; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(30, 90)), -1, -1);
      rd_index = 4'($urandom_range(15)); #1;
      chk("rd_key_random", rd_key, (rd_index <= 4'd10) ? ek[rd_index] : 128'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
